// File: rtl/mul_iter_radix256.sv
// mul_iter_radix256: iterative 32x32 multiplier retiring one multiplier byte per cycle, with signed and accumulate options
module mul_iter_radix256 #(
    parameter bit EARLY_TERM = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        is_signed_i,
    input  logic        acc_en_i,
    input  logic [63:0] acc_in_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [63:0] product_o
);
    typedef enum logic [1:0] {IDLE, ITER, FINAL} state_t;
    state_t      state_q;
    logic [31:0] mag_a_q, mag_b_q;
    logic [63:0] acc_q, acc_in_q, product_q;
    logic [1:0]  k_q;
    logic        neg_q, acc_en_q, busy_q, done_q;
    logic [5:0]  sh, sh_nxt;
    logic [2:0]  k1;
    logic [7:0]  b_byte;
    logic [39:0] pp;
    logic [63:0] acc_d, product_d;
    logic [31:0] mag_a_d, mag_b_d;
    logic        last;
    always_comb begin
        sh        = {1'b0, k_q, 3'b000};
        k1        = {1'b0, k_q} + 3'd1;
        sh_nxt    = {k1, 3'b000};
        b_byte    = 8'(mag_b_q >> sh);
        pp        = {8'b0, mag_a_q} * {32'b0, b_byte};
        acc_d     = acc_q + ({24'b0, pp} << sh);
        // a shift of 32 clears everything, so k=3 also reads as "nothing left"
        last      = (k_q == 2'd3) || (EARLY_TERM && ((mag_b_q >> sh_nxt) == 32'd0));
        product_d = (neg_q ? -acc_q : acc_q) + (acc_en_q ? acc_in_q : 64'd0);
        mag_a_d   = (is_signed_i && op_a_i[31]) ? -op_a_i : op_a_i;
        mag_b_d   = (is_signed_i && op_b_i[31]) ? -op_b_i : op_b_i;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            acc_q     <= '0;
            acc_in_q  <= '0;
            product_q <= '0;
            k_q       <= '0;
            neg_q     <= 1'b0;
            acc_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        mag_a_q  <= mag_a_d;
                        mag_b_q  <= mag_b_d;
                        neg_q    <= is_signed_i & (op_a_i[31] ^ op_b_i[31]);
                        acc_en_q <= acc_en_i;
                        acc_in_q <= acc_in_i;
                        acc_q    <= '0;
                        k_q      <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ITER;
                    end
                end
                ITER: begin
                    acc_q <= acc_d;
                    k_q   <= k_q + 2'd1;
                    if (last) state_q <= FINAL;
                end
                FINAL: begin
                    product_q <= product_d;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = product_q;
endmodule

// File: tb/tb_mul_iter_radix256.sv
// tb_mul_iter_radix256: directed checks of both early-terminating and fixed-length multiplier variants
module tb_mul_iter_radix256;
    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [31:0] op_a, op_b;
    logic        is_signed, acc_en;
    logic [63:0] acc_in;
    logic        busy1, done1, busy0, done0;
    logic [63:0] prod1, prod0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    mul_iter_radix256 #(.EARLY_TERM(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .op_a_i(op_a), .op_b_i(op_b),
        .is_signed_i(is_signed), .acc_en_i(acc_en), .acc_in_i(acc_in),
        .busy_o(busy1), .done_o(done1), .product_o(prod1)
    );
    mul_iter_radix256 #(.EARLY_TERM(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .op_a_i(op_a), .op_b_i(op_b),
        .is_signed_i(is_signed), .acc_en_i(acc_en), .acc_in_i(acc_in),
        .busy_o(busy0), .done_o(done0), .product_o(prod0)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic ae, input logic [63:0] ai);
        op_a = a; op_b = b; is_signed = s; acc_en = ae; acc_in = ai; start = 1'b1;
    endtask

    // runs one op on both variants; n is the significant-byte count of |op_b|
    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic ae, input logic [63:0] ai,
                       input logic [63:0] exp, input int n);
        int cyc = 0;
        int lat1 = -1;
        int lat0 = -1;
        drive(a, b, s, ae, ai);
        while ((lat1 < 0 || lat0 < 0) && cyc < 12) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            op_a = $urandom; op_b = $urandom; acc_in = {$urandom, $urandom};
            if (cyc == 1) begin
                chk({tag, " busy1"}, 64'(busy1), 64'd1);
                chk({tag, " busy0"}, 64'(busy0), 64'd1);
            end
            if (lat1 > 0 && cyc == lat1 + 1) chk({tag, " done1 width"}, 64'(done1), 64'd0);
            if (done1 && lat1 < 0) begin
                lat1 = cyc;
                chk({tag, " prod1"}, prod1, exp);
                chk({tag, " busy1 at done"}, 64'(busy1), 64'd0);
            end
            if (done0 && lat0 < 0) begin
                lat0 = cyc;
                chk({tag, " prod0"}, prod0, exp);
            end
        end
        chk({tag, " lat1"}, 64'(lat1), 64'(n + 2));
        chk({tag, " lat0"}, 64'(lat0), 64'd6);
        @(negedge clk);
        chk({tag, " done0 width"}, 64'(done0), 64'd0);
        chk({tag, " done1 after"}, 64'(done1), 64'd0);
        chk({tag, " prod1 held"}, prod1, exp);
    endtask

    initial begin
        int cyc, cnt1, cnt0, lat;
        rst_n = 1'b0; start = 1'b0;
        op_a = '0; op_b = '0; is_signed = 1'b0; acc_en = 1'b0; acc_in = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", 64'(busy1), 64'd0);
        chk("reset done", 64'(done1), 64'd0);
        chk("reset product", prod1, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run("umax",       32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'd0, 64'hFFFFFFFE00000001, 4);
        run("early",      32'h12345678, 32'h00000005, 1'b0, 1'b0, 64'd0, 64'h000000005B05B058, 1);
        run("three byte", 32'h00000010, 32'h00ABCDEF, 1'b0, 1'b0, 64'd0, 64'h000000000ABCDEF0, 3);
        run("smin",       32'h80000000, 32'h80000000, 1'b1, 1'b0, 64'd0, 64'h4000000000000000, 4);
        run("smla",       32'hFFFFFFFD, 32'h00000007, 1'b1, 1'b1, 64'd100, 64'h000000000000004F, 1);
        run("smul neg",   32'hFFFFFFFD, 32'h00000007, 1'b1, 1'b1, 64'd0, 64'hFFFFFFFFFFFFFFEB, 1);
        run("neg zero",   32'h00000000, 32'hFFFFFFFB, 1'b1, 1'b0, 64'd0, 64'h0000000000000000, 1);
        run("zero acc",   32'h00001234, 32'h00000000, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1);
        run("wrap",       32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 64'h0000000200000000, 64'h0000000000000001, 4);

        // start pulse while busy must be dropped
        drive(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'd0);
        cyc = 0; cnt1 = 0; cnt0 = 0; lat = -1;
        while (cyc < 14) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == 2) drive(32'd1, 32'd1, 1'b0, 1'b0, 64'd0);
            if (done1) begin
                cnt1++;
                lat = cyc;
                chk("ignore prod1", prod1, 64'hFFFFFFFE00000001);
            end
            if (done0) cnt0++;
        end
        chk("ignore count1", 64'(cnt1), 64'd1);
        chk("ignore count0", 64'(cnt0), 64'd1);
        chk("ignore lat", 64'(lat), 64'd6);

        // reset at E2 abandons the op
        drive(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'd0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst busy", 64'(busy1), 64'd0);
        chk("rst done", 64'(done1), 64'd0);
        chk("rst product", prod1, 64'd0);
        chk("rst product0", prod0, 64'd0);
        rst_n = 1'b1;
        cnt1 = 0;
        repeat (10) begin
            @(negedge clk);
            if (done1 || done0) cnt1++;
        end
        chk("rst no done", 64'(cnt1), 64'd0);

        // start in the done cycle is accepted
        drive(32'h12345678, 32'h00000005, 1'b0, 1'b0, 64'd0);
        cyc = 0;
        while (!done1 && cyc < 12) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
        end
        chk("b2b first lat", 64'(cyc), 64'd3);
        chk("b2b first prod", prod1, 64'h000000005B05B058);
        drive(32'hFFFFFFFD, 32'h00000007, 1'b1, 1'b1, 64'd100);
        @(negedge clk);
        start = 1'b0;
        chk("b2b busy", 64'(busy1), 64'd1);
        cyc = 1;
        while (!done1 && cyc < 12) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b second lat", 64'(cyc), 64'd3);
        chk("b2b second prod", prod1, 64'h000000000000004F);
        repeat (8) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
